// File: rtl/axi4_lite_mem_pkg.sv
// Shared types for the axi4_lite_mem AXI4-Lite RAM subordinate.
// Optional range checking is enabled with AXI4_LITE_MEM_RANGE_CHECK_EN.
package axi4_lite_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

endpackage

// File: rtl/axi4_lite_mem_array.sv
// DEPTH x 32 synchronous RAM: one byte-enabled write port, one registered
// read port; a read and write to the same word on one edge returns old data.
module axi4_lite_mem_array
    import axi4_lite_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [STRB_W-1:0]        i_wstrb,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_mem.sv
// AXI4-Lite subordinate over a word-addressed RAM, one outstanding access per
// direction. Define AXI4_LITE_MEM_RANGE_CHECK_EN to answer SLVERR above DEPTH*4.
module axi4_lite_mem
    import axi4_lite_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    axi_resp_t         r_bresp;
    wr_state_t         r_wstate;

    logic              r_arready, r_rvalid, r_rzero;
    axi_resp_t         r_rresp;
    rd_state_t         r_rstate;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_we;
    logic              w_wr_oor, w_rd_oor;
    logic [31:0]       w_ram_rdata;
    logic              w_unused_addr;

    assign w_aw_hs  = awvalid & r_awready;
    assign w_w_hs   = wvalid & r_wready;
    assign w_ar_hs  = arvalid & r_arready;
    assign w_commit = (r_wstate == W_COLLECT) & r_aw_held & r_w_held;
    assign w_we     = w_commit & ~w_wr_oor;

`ifdef AXI4_LITE_MEM_RANGE_CHECK_EN
    assign w_wr_oor = |r_awaddr[ADDR_W-1:IDX_W+2];
    assign w_rd_oor = |araddr[ADDR_W-1:IDX_W+2];
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    assign w_unused_addr = ^{r_awaddr[1:0], araddr[1:0],
                             r_awaddr[ADDR_W-1:IDX_W+2], araddr[ADDR_W-1:IDX_W+2]};

    // Each ready drops after its own handshake; commit happens once both halves are latched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wstate  <= W_COLLECT;
        end else begin
            case (r_wstate)
                W_COLLECT: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= awaddr;
                        r_aw_held <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_held) begin
                        r_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb;
                        r_w_held <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_held) begin
                        r_wready <= 1'b1;
                    end
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_oor ? SLVERR : OKAY;
                        r_wstate  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_COLLECT;
                    end
                end
                default: r_wstate <= W_COLLECT;
            endcase
        end
    end

    // r_rzero masks the RAM output so rdata reads 0 after reset and on rejected reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rzero   <= 1'b1;
            r_rstate  <= R_IDLE;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_rd_oor ? SLVERR : OKAY;
                        r_rzero   <= w_rd_oor;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    axi4_lite_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (aclk),
        .i_we    (w_we),
        .i_waddr (r_awaddr[IDX_W+1:2]),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_ar_hs & ~w_rd_oor),
        .i_raddr (araddr[IDX_W+1:2]),
        .o_rdata (w_ram_rdata)
    );

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rresp   = r_rresp;
    assign rdata   = r_rzero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_axi4_lite_mem.sv
// Directed bench for axi4_lite_mem with a word-array reference model and a
// per-cycle response checker.
module tb_axi4_lite_mem;

    localparam int unsigned DEPTH = 256;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    int          n_tests = 0, n_fail = 0, n_writes = 0, n_bpulse = 0;
    logic        prev_bvalid = 1'b0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] rexp_d [$];
    logic [1:0]  rexp_r [$];
    logic [1:0]  bexp [$];
    logic [31:0] got;

    always #5 aclk = ~aclk;

    axi4_lite_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
`ifdef AXI4_LITE_MEM_RANGE_CHECK_EN
        return a < DEPTH * 4;
`else
        return a == a;
`endif
    endfunction

    function automatic int unsigned idx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[idx(a)][8*b +: 8] = d[8*b +: 8];
        end
        bexp.push_back(in_range(a) ? 2'b00 : 2'b10);
        n_writes++;
    endtask

    task automatic model_read(input logic [31:0] a);
        rexp_d.push_back(in_range(a) ? model_mem[idx(a)] : 32'h0);
        rexp_r.push_back(in_range(a) ? 2'b00 : 2'b10);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_readies", {awready, wready, arready}, 0);
        chk("rst_valids", {bvalid, rvalid}, 0);
        chk("rst_resps", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
    endtask

    // Response checker: every handshake is matched against the model's queue.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bvalid && !prev_bvalid) n_bpulse++;
            prev_bvalid = bvalid;
            if (bvalid) chk("aw_w_blocked_during_b", {awready, wready}, 0);
            if (rvalid) chk("ar_blocked_during_r", arready, 0);
            if (bvalid && bready) begin
                if (bexp.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", bresp, bexp.pop_front());
            end
            if (rvalid && rready) begin
                if (rexp_d.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    chk("rdata", rdata, rexp_d.pop_front());
                    chk("rresp", rresp, rexp_r.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bstall);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        logic [1:0] held_resp;
        model_write(a, d, s);
        awaddr = a; wdata = d; wstrb = s;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            wvalid  = !w_done;
            awvalid = !aw_done && (c >= lead);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (w_done && !aw_done) chk("wready_low_after_w", wready, 0);
        end
        awvalid = 0; wvalid = 0;
        chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
        chk("b_not_early", bvalid, 0);
        step();
        chk("b_latency", bvalid, 1);
        held_resp = bresp;
        for (int k = 0; k < bstall; k++) begin
            step();
            chk("b_held", {bvalid, bresp}, {1'b1, held_resp});
        end
        bready = 1;
        step();
        bready = 0;
        chk("b_dropped", bvalid, 0);
        chk("aw_w_reopen", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rstall, output logic [31:0] d);
        bit hs, done = 0;
        logic [31:0] held;
        model_read(a);
        araddr = a; arvalid = 1;
        for (int c = 0; c < 40 && !done; c++) begin
            hs = arvalid && arready;
            step();
            if (hs) done = 1;
        end
        arvalid = 0;
        chk("ar_accepted", done, 1);
        chk("r_latency", rvalid, 1);
        d = rdata;
        held = rdata;
        for (int k = 0; k < rstall; k++) begin
            step();
            chk("r_held", {rvalid, arready}, 2'b10);
            chk("rdata_held", rdata, held);
        end
        rready = 1;
        step();
        rready = 0;
        chk("r_dropped", rvalid, 0);
        chk("ar_reopen", arready, 1);
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        check_reset_vals();
        aresetn = 1;
        step();
        chk("ready_after_release", {awready, wready, arready}, 3'b111);

        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(32'h10, 0, got);
        chk("lit_full_word", got, 32'hDEADBEEF);

        axi_write(32'h10, 32'h0000CAFE, 4'b0011, 0, 0);
        axi_read(32'h10, 0, got);
        chk("lit_low_lanes", got, 32'hDEADCAFE);

        axi_write(32'h12, 32'hFFFFFFFF, 4'b0000, 0, 0);
        axi_read(32'h10, 0, got);
        chk("lit_no_strobe", got, 32'hDEADCAFE);

        axi_write(32'h20, 32'hA5A5A5A5, 4'hF, 3, 5);
        axi_read(32'h20, 5, got);
        axi_write(32'h30, 32'h0BADF00D, 4'hF, 0, 0);

        // AR handshake on the same edge as the RAM write to that word
        model_read(32'h30);
        model_write(32'h30, 32'h5555AAAA, 4'hF);
        chk("rbw_ready", {awready, wready, arready}, 3'b111);
        awaddr = 32'h30; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0; araddr = 32'h30; arvalid = 1;
        step();
        arvalid = 0;
        chk("rbw_both_valid", {bvalid, rvalid}, 2'b11);
        chk("lit_rbw_old", rdata, 32'h0BADF00D);
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        axi_read(32'h30, 0, got);
        chk("lit_rbw_new", got, 32'h5555AAAA);

        axi_write(32'h000, 32'h12345678, 4'hF, 0, 0);
        axi_write(32'h400, 32'h11111111, 4'hF, 0, 0);
        axi_read(32'h000, 0, got);
`ifdef AXI4_LITE_MEM_RANGE_CHECK_EN
        chk("lit_oor_word0", got, 32'h12345678);
`else
        chk("lit_wrap_word0", got, 32'h11111111);
`endif
        axi_read(32'h400, 0, got);
`ifdef AXI4_LITE_MEM_RANGE_CHECK_EN
        chk("lit_oor_rdata", got, 32'h0);
`else
        chk("lit_wrap_rdata", got, 32'h11111111);
`endif

        awaddr = 32'h20; awvalid = 1;
        step();
        awvalid = 0;
        aresetn = 0;
        #1;
        check_reset_vals();
        step();
        aresetn = 1;
        step();
        chk("ready_after_midreset", {awready, wready, arready}, 3'b111);
        chk("no_b_after_midreset", bvalid, 0);
        axi_read(32'h20, 0, got);
        chk("lit_midreset_unchanged", got, 32'hA5A5A5A5);
        axi_write(32'h44, 32'hCAFEF00D, 4'hF, 0, 2);
        axi_read(32'h44, 2, got);
        chk("lit_fresh_write", got, 32'hCAFEF00D);

        step();
        chk("b_pulse_count", n_bpulse, n_writes);
        chk("queues_drained", bexp.size() + rexp_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
